multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle RISC-V control FSM for the shared-datapath processor. It sequences each instruction through fetch, decode, execute, memory and writeback states. Supported classes are R-type, `addi`, `ld`, `sd`, `beq` and optionally `jal`. It handshakes with a variable-latency memory, traps on illegal opcodes or memory timeout, and counts retired instructions.

## Interface
- `ALUOP_W`, default 2: width of `ALUOp`. Codes 00/01/10 are zero-extended. Must be ≥2.
- `SUPPORT_JAL`, default 1: when 1, decode `jal` (1101111). When 0, `jal` is illegal.
- `MEM_TIMEOUT`, default 15: maximum wait cycles without `mem_ready` before trapping. Range 1..255.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7: `IR[6:0]`. Stable from DECODE until the instruction retires.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `pc_write` out 1: PC load enable.
- `ir_write` out 1: IR/MDR load enable.
- `IorD` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `MemToReg` out 2: writeback source. 0 = ALUOut, 1 = MDR, 2 = PC.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 2: ALU A input. 0 = PC, 1 = rs1, 2 = oldPC.
- `ALUSrcB` out 2: ALU B input. 0 = rs2, 1 = constant 4, 2 = imm.
- `ALUOp` out `ALUOP_W`: ALU operation code.
- `PCSource` out 1: PC source. 0 = ALU result, 1 = ALUOut.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: sticky flag, illegal opcode.
- `mem_err` out 1: sticky flag, memory timeout.
- `instret` out `CNT_W`: retired-instruction count.
- `state` out 4: current state encoding, for debug.

## Operation
States and encodings:
- FETCH = 0
- DECODE = 1
- MEM_ADDR = 2
- MEM_READ = 3
- MEM_WB = 4
- MEM_WRITE = 5
- EXEC_R = 6
- EXEC_I = 7
- ALU_WB = 8
- BRANCH = 9
- JAL = 10
- TRAP = 11

Outputs are decoded from `state`, plus `mem_ready` and `zero` where noted. Any output not listed for a state is 0.

- **FETCH:** `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=1.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, next state DECODE.
  - Otherwise: stay in FETCH.
- **DECODE:** `ALUSrcA`=2, `ALUSrcB`=2, `ALUOp`=00. This latches the branch target into ALUOut. Next state by `opcode`:
  - 0000011 or 0100011 → MEM_ADDR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 with `SUPPORT_JAL`=1 → JAL
  - anything else → TRAP, and set `illegal`.
- **MEM_ADDR:** `ALUSrcA`=1, `ALUSrcB`=2, `ALUOp`=00. Next state is MEM_READ if `opcode`=0000011, else MEM_WRITE.
- **MEM_READ:** `MemRead`=1, `IorD`=1.
  - When `mem_ready`=1: `ir_write`=1 (loads MDR), next state MEM_WB.
- **MEM_WB:** `RegWrite`=1, `MemToReg`=1, retire, next state FETCH.
- **MEM_WRITE:** `MemWrite`=1, `IorD`=1.
  - When `mem_ready`=1: retire, next state FETCH.
- **EXEC_R:** `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=10, next state ALU_WB.
- **EXEC_I:** `ALUSrcA`=1, `ALUSrcB`=2, `ALUOp`=10, next state ALU_WB.
- **ALU_WB:** `RegWrite`=1, `MemToReg`=0, retire, next state FETCH.
- **BRANCH:** `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=01, `PCSource`=1, `pc_write`=`zero`. Retire, next state FETCH.
- **JAL:** `RegWrite`=1, `MemToReg`=2 (PC already holds oldPC+4), `PCSource`=1, `pc_write`=1. Retire, next state FETCH.
- **TRAP:** all enables 0. Absorbing state; only `reset` exits.

Retire means: `instr_done`=1 for that cycle, and `instret` increments by 1, wrapping modulo 2^`CNT_W`.

Memory wait counter:
- 8-bit counter, cleared on entry to FETCH, MEM_READ or MEM_WRITE, and whenever `mem_ready`=1.
- Increments each cycle spent in one of those states with `mem_ready`=0.
- When it equals `MEM_TIMEOUT` and `mem_ready` is still 0, the next state is TRAP and `mem_err` is set.
- If `mem_ready`=1 in that same cycle, the handshake completes and no trap occurs.

## Timing
- **Reset:** `reset` high at an edge sets:
  - `state`=FETCH
  - wait counter = 0
  - `instret`=0
  - `illegal`=0, `mem_err`=0
  - While `reset` is high, all enable outputs are forced to 0: `pc_write`, `ir_write`, `MemRead`, `MemWrite`, `RegWrite`, `instr_done`.
- **Reset mid-instruction:** the instruction is abandoned, with no retire pulse and no count.
- **Latency with zero-wait memory** (`mem_ready` high on the first request cycle), FETCH through retire inclusive:
  - R-type and `addi`: 4 cycles
  - `ld`: 5 cycles
  - `sd`: 4 cycles
  - `beq`: 3 cycles
  - `jal`: 3 cycles
- **Wait states:** each memory wait cycle adds exactly 1 cycle.
- **Request hold:** `MemRead`/`MemWrite` stay asserted continuously until the cycle in which `mem_ready`=1. Memory must not see the request drop early.
- **Ignored `mem_ready`:** the FSM ignores `mem_ready` in non-memory states.
- **Sticky flags:** `illegal` and `mem_err` both assert on the edge that enters TRAP.

## Test plan
- **Basic sequencing:** reset 2 cycles, then program R, addi, ld, sd, beq with `mem_ready` tied 1 → state trace 0,1,6,8 / 0,1,7,8 / 0,1,2,3,4 / 0,1,2,5 / 0,1,9; `instret`=5 and 5 `instr_done` pulses.
- **beq both ways:** `zero`=1 → `pc_write`=1 and `PCSource`=1 in BRANCH. `zero`=0 → `pc_write`=0 and retire still occurs.
- **Wait states and timeout:** `ld` with `mem_ready` delayed 3 cycles in MEM_READ → 8 cycles total with `MemRead` held throughout. `mem_ready` held 0 in FETCH with `MEM_TIMEOUT`=15 → TRAP after 16 cycles, `mem_err`=1, `illegal`=0. Ready arriving exactly at the limit → no trap.
- **Illegal and `jal` handling:** `opcode`=1111111 → TRAP, `illegal`=1. `jal` with `SUPPORT_JAL`=0 → TRAP. `jal` with `SUPPORT_JAL`=1 → JAL with `MemToReg`=2, `RegWrite`=1, `pc_write`=1.
- **Reset mid-instruction:** `reset` asserted in MEM_READ, and again in TRAP → next state FETCH, flags cleared, `instret`=0, no `MemRead` while reset is high.
- **Counter wrap:** `CNT_W`=4, retire 17 instructions → `instret`=1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Control FSM for a shared-datapath multi-cycle RISC-V core. Each instruction
// is sequenced through fetch, decode, execute, memory and writeback states.
// Supports R-type, addi, ld, sd, beq and (optionally) jal. Memory accesses
// handshake on mem_ready with a bounded wait; illegal opcodes and memory
// timeouts enter an absorbing TRAP state. Retired instructions are counted.
//
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   opcode            : IR[6:0], stable from DECODE until retire
//   zero              : ALU zero flag (branch decision)
//   mem_ready         : memory completes current read/write this cycle
//   pc_write, ir_write, IorD, MemRead, MemWrite, MemToReg, RegWrite,
//   ALUSrcA, ALUSrcB, ALUOp, PCSource : datapath controls
//   instr_done        : one-cycle retire pulse
//   illegal, mem_err  : sticky trap causes
//   instret           : retired-instruction count (wraps)
//   state             : current state encoding (debug)
module multicycle_control_unit #(
  parameter int unsigned ALUOP_W     = 2,
  parameter bit          SUPPORT_JAL = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         MemToReg,
  output logic               RegWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               PCSource,
  output logic               instr_done,
  output logic               illegal,
  output logic               mem_err,
  output logic [CNT_W-1:0]   instret,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_TRAP      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [7:0] WAIT_LIM = 8'(MEM_TIMEOUT);

  state_t             state_q, state_d;
  logic [7:0]         wait_q, wait_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               illegal_q, illegal_d;
  logic               mem_err_q, mem_err_d;

  logic pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c, retire_c;
  logic in_mem_wait, timeout;

  always_comb begin
    in_mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                  (state_q == S_MEM_WRITE);
    timeout     = in_mem_wait && !mem_ready && (wait_q == WAIT_LIM);
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    retire_c    = 1'b0;
    IorD        = 1'b0;
    MemToReg    = 2'd0;
    ALUSrcA     = 2'd0;
    ALUSrcB     = 2'd0;
    ALUOp       = '0;
    PCSource    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        ALUSrcB    = 2'd1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd2;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BEQ:            state_d = S_BRANCH;
          OP_JAL:            state_d = SUPPORT_JAL ? S_JAL : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read_c = 1'b1;
        IorD       = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        reg_write_c = 1'b1;
        MemToReg    = 2'd1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_c = 1'b1;
        IorD        = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 2'd1;
        ALUOp   = ALUOP_W'(2'b10);
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        ALUOp   = ALUOP_W'(2'b10);
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'd1;
        ALUOp      = ALUOP_W'(2'b01);
        PCSource   = 1'b1;
        pc_write_c = zero;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        reg_write_c = 1'b1;
        MemToReg    = 2'd2;
        PCSource    = 1'b1;
        pc_write_c  = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Timeout only fires with mem_ready low, so it never overrides a
    // completing handshake; it simply redirects a would-be stay.
    if (timeout) state_d = S_TRAP;

    // Counter runs only while waiting in place; any entry, completion or
    // exit leaves it at zero.
    if (in_mem_wait && !mem_ready && (state_d == state_q))
      wait_d = wait_q + 8'd1;
    else
      wait_d = '0;

    instret_d = retire_c ? instret_q + CNT_W'(1) : instret_q;
    illegal_d = illegal_q | ((state_q == S_DECODE) && (state_d == S_TRAP));
    mem_err_d = mem_err_q | timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Enables are suppressed while reset is held so nothing reaches memory
  // or the register file from a stale state.
  assign pc_write   = pc_write_c  & ~reset;
  assign ir_write   = ir_write_c  & ~reset;
  assign MemRead    = mem_read_c  & ~reset;
  assign MemWrite   = mem_write_c & ~reset;
  assign RegWrite   = reg_write_c & ~reset;
  assign instr_done = retire_c    & ~reset;
  assign illegal    = illegal_q;
  assign mem_err    = mem_err_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEM_ADDR = 2, ST_MEM_READ = 3,
                 ST_MEM_WB = 4, ST_MEM_WRITE = 5, ST_EXEC_R = 6, ST_EXEC_I = 7,
                 ST_ALU_WB = 8, ST_BRANCH = 9, ST_JAL = 10, ST_TRAP = 11;
  localparam bit [6:0] OP_LD = 7'b0000011, OP_SD = 7'b0100011, OP_R = 7'b0110011,
                       OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: defaults. DUT B: 3-bit ALUOp, no jal, short timeout, 4-bit counter.
  logic rst_a, zero_a, rdy_a, rst_b, zero_b, rdy_b;
  logic [6:0] opc_a, opc_b;
  logic pcw_a, irw_a, iord_a, mr_a, mw_a, rw_a, pcs_a, done_a, ill_a, merr_a;
  logic pcw_b, irw_b, iord_b, mr_b, mw_b, rw_b, pcs_b, done_b, ill_b, merr_b;
  logic [1:0] m2r_a, sa_a, sb_a, m2r_b, sa_b, sb_b, aop_a;
  logic [2:0] aop_b;
  logic [31:0] cnt_a;
  logic [3:0] cnt_b, st_a, st_b;

  multicycle_control_unit dut_a (
    .clk(clk), .reset(rst_a), .opcode(opc_a), .zero(zero_a), .mem_ready(rdy_a),
    .pc_write(pcw_a), .ir_write(irw_a), .IorD(iord_a), .MemRead(mr_a), .MemWrite(mw_a),
    .MemToReg(m2r_a), .RegWrite(rw_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ALUOp(aop_a),
    .PCSource(pcs_a), .instr_done(done_a), .illegal(ill_a), .mem_err(merr_a),
    .instret(cnt_a), .state(st_a));

  multicycle_control_unit #(.ALUOP_W(3), .SUPPORT_JAL(1'b0), .MEM_TIMEOUT(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(rst_b), .opcode(opc_b), .zero(zero_b), .mem_ready(rdy_b),
    .pc_write(pcw_b), .ir_write(irw_b), .IorD(iord_b), .MemRead(mr_b), .MemWrite(mw_b),
    .MemToReg(m2r_b), .RegWrite(rw_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ALUOp(aop_b),
    .PCSource(pcs_b), .instr_done(done_b), .illegal(ill_b), .mem_err(merr_b),
    .instret(cnt_b), .state(st_b));

  // One expected cycle: inputs to apply plus the model's view of that cycle.
  typedef struct {
    bit d; int st; bit known, rst, rdy, zero, retire, ill, merr;
    bit [6:0] opc; int unsigned cnt;
  } entry_t;

  typedef struct packed {
    bit pcw, irw, iord, mr, mw; bit [1:0] m2r; bit rw; bit [1:0] sa, sb;
    bit [2:0] aop; bit pcs;
  } outs_t;

  entry_t q[$];
  entry_t cur;
  bit cur_valid = 1'b0;
  int checks = 0, failures = 0, done_cnt_a = 0;

  // Model / builder state
  bit cur_d, c_jal, tie1, aborted, m_ill, m_merr, cur_zero;
  int c_to, pos, abort_at, last_mem_n;
  int unsigned c_mask, m_cnt;
  bit [6:0] cur_opc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit rnd_rdy();
    return tie1 ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  function automatic void set_cfg(input bit d);
    cur_d = d;
    c_jal = (d == 1'b0);
    c_to = d ? 3 : 15;
    c_mask = d ? 32'hF : 32'hFFFF_FFFF;
  endfunction

  function automatic void push_reset(input int st, input bit known);
    entry_t e;
    e.d = cur_d; e.st = st; e.known = known; e.rst = 1'b1; e.rdy = rnd_rdy();
    e.zero = 1'($urandom_range(0, 1)); e.retire = 1'b0; e.ill = m_ill; e.merr = m_merr;
    e.opc = 7'($urandom); e.cnt = m_cnt & c_mask;
    q.push_back(e);
    m_cnt = 0; m_ill = 1'b0; m_merr = 1'b0;
  endfunction

  function automatic void push(input int st, input bit rdy, input bit ret);
    entry_t e;
    if (aborted) return;
    e.d = cur_d; e.st = st; e.known = 1'b1; e.rst = 1'b0; e.rdy = rdy; e.zero = cur_zero;
    e.retire = ret; e.ill = m_ill; e.merr = m_merr; e.cnt = m_cnt & c_mask;
    // opcode is only guaranteed stable from DECODE on; scramble it in FETCH
    e.opc = (st == ST_FETCH) ? 7'($urandom) : cur_opc;
    if (pos == abort_at) begin
      e.rst = 1'b1; aborted = 1'b1; m_cnt = 0; m_ill = 1'b0; m_merr = 1'b0;
    end else if (ret) m_cnt++;
    pos++;
    q.push_back(e);
  endfunction

  function automatic void trap_seq(input bit is_ill);
    if (aborted) return;
    if (is_ill) m_ill = 1'b1; else m_merr = 1'b1;
    for (int i = 0; i < 3; i++) push(ST_TRAP, rnd_rdy(), 1'b0);
    push_reset(ST_TRAP, 1'b1);
    push_reset(ST_FETCH, 1'b1);
  endfunction

  // Returns 1 if the access times out.
  function automatic bit mem_phase(input int st, input int waits, input bit ret);
    int n;
    n = (waits > c_to) ? c_to + 1 : waits;
    for (int i = 0; i < n; i++) push(st, 1'b0, 1'b0);
    if (waits > c_to) begin
      last_mem_n = n;
      trap_seq(1'b0);
      return 1'b1;
    end
    last_mem_n = n + 1;
    push(st, 1'b1, ret);
    return 1'b0;
  endfunction

  function automatic void do_instr(input bit [6:0] opc, input bit z, input int wf,
                                   input int wm, input int abort);
    cur_opc = opc; cur_zero = z; pos = 0; aborted = 1'b0; abort_at = abort;
    if (mem_phase(ST_FETCH, wf, 1'b0)) return;
    push(ST_DECODE, rnd_rdy(), 1'b0);
    if (opc == OP_LD) begin
      push(ST_MEM_ADDR, rnd_rdy(), 1'b0);
      if (mem_phase(ST_MEM_READ, wm, 1'b0)) return;
      push(ST_MEM_WB, rnd_rdy(), 1'b1);
    end else if (opc == OP_SD) begin
      push(ST_MEM_ADDR, rnd_rdy(), 1'b0);
      void'(mem_phase(ST_MEM_WRITE, wm, 1'b1));
    end else if (opc == OP_R) begin
      push(ST_EXEC_R, rnd_rdy(), 1'b0); push(ST_ALU_WB, rnd_rdy(), 1'b1);
    end else if (opc == OP_I) begin
      push(ST_EXEC_I, rnd_rdy(), 1'b0); push(ST_ALU_WB, rnd_rdy(), 1'b1);
    end else if (opc == OP_BEQ) begin
      push(ST_BRANCH, rnd_rdy(), 1'b1);
    end else if (opc == OP_JAL && c_jal) begin
      push(ST_JAL, rnd_rdy(), 1'b1);
    end else begin
      trap_seq(1'b1);
    end
  endfunction

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 39);
    if (r == 0) return c_to + 1;
    if (r < 3) return c_to;
    return $urandom_range(0, 3);
  endfunction

  function automatic void rand_instr();
    bit [6:0] opc;
    int k;
    k = $urandom_range(0, 13);
    case (k)
      0, 1: opc = OP_R;    2, 3: opc = OP_I;   4, 5: opc = OP_LD;
      6, 7: opc = OP_SD;   8, 9: opc = OP_BEQ; 10, 11: opc = OP_JAL;
      default: begin
        opc = 7'($urandom);
        while (opc inside {OP_R, OP_I, OP_LD, OP_SD, OP_BEQ, OP_JAL}) opc = 7'($urandom);
      end
    endcase
    do_instr(opc, 1'($urandom_range(0, 1)), pick_wait(), pick_wait(),
             ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1);
  endfunction

  // Expected outputs from the per-state output rules.
  function automatic outs_t exp_outs(input entry_t e);
    outs_t o;
    int s;
    s = e.st;
    o = '0;
    o.mr   = (s == ST_FETCH) || (s == ST_MEM_READ);
    o.mw   = (s == ST_MEM_WRITE);
    o.iord = (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    o.irw  = o.mr && e.rdy;
    o.pcw  = (s == ST_FETCH && e.rdy) || (s == ST_BRANCH && e.zero) || (s == ST_JAL);
    o.rw   = s inside {ST_MEM_WB, ST_ALU_WB, ST_JAL};
    o.m2r  = (s == ST_MEM_WB) ? 2'd1 : (s == ST_JAL) ? 2'd2 : 2'd0;
    o.sa   = (s == ST_DECODE) ? 2'd2 :
             (s inside {ST_MEM_ADDR, ST_EXEC_R, ST_EXEC_I, ST_BRANCH}) ? 2'd1 : 2'd0;
    o.sb   = (s == ST_FETCH) ? 2'd1 :
             (s inside {ST_DECODE, ST_MEM_ADDR, ST_EXEC_I}) ? 2'd2 : 2'd0;
    o.aop  = (s inside {ST_EXEC_R, ST_EXEC_I}) ? 3'd2 : (s == ST_BRANCH) ? 3'd1 : 3'd0;
    o.pcs  = (s == ST_BRANCH) || (s == ST_JAL);
    if (e.rst) begin o.pcw = 0; o.irw = 0; o.mr = 0; o.mw = 0; o.rw = 0; end
    return o;
  endfunction

  outs_t act;
  always_comb begin
    if (cur.d)
      act = '{pcw_b, irw_b, iord_b, mr_b, mw_b, m2r_b, rw_b, sa_b, sb_b, aop_b, pcs_b};
    else
      act = '{pcw_a, irw_a, iord_a, mr_a, mw_a, m2r_a, rw_a, sa_a, sb_a, {1'b0, aop_a}, pcs_a};
  end

  always @(negedge clk) if (done_a && !rst_a) done_cnt_a++;

  // Compare process: every driven cycle is checked at the falling edge.
  always @(negedge clk) begin
    if (cur_valid) begin
      outs_t ex;
      ex = exp_outs(cur);
      chk("pc_write", act.pcw, ex.pcw);
      chk("ir_write", act.irw, ex.irw);
      chk("MemRead", act.mr, ex.mr);
      chk("MemWrite", act.mw, ex.mw);
      chk("RegWrite", act.rw, ex.rw);
      chk("instr_done", cur.d ? done_b : done_a, cur.retire && !cur.rst);
      if (cur.known) begin
        chk("state", cur.d ? st_b : st_a, cur.st);
        chk("IorD", act.iord, ex.iord);
        chk("MemToReg", act.m2r, ex.m2r);
        chk("ALUSrcA", act.sa, ex.sa);
        chk("ALUSrcB", act.sb, ex.sb);
        chk("ALUOp", act.aop, ex.aop);
        chk("PCSource", act.pcs, ex.pcs);
        chk("instret", cur.d ? {28'd0, cnt_b} : cnt_a, cur.cnt);
        chk("illegal", cur.d ? ill_b : ill_a, cur.ill);
        chk("mem_err", cur.d ? merr_b : merr_a, cur.merr);
      end
    end
  end

  task automatic run_queue();
    while (q.size() > 0) begin
      cur = q.pop_front();
      cur_valid = 1'b1;
      if (cur.d == 1'b0) begin
        rst_a = cur.rst; rdy_a = cur.rdy; zero_a = cur.zero; opc_a = cur.opc; rst_b = 1'b1;
      end else begin
        rst_b = cur.rst; rdy_b = cur.rdy; zero_b = cur.zero; opc_b = cur.opc; rst_a = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    cur_valid = 1'b0;
  endtask

  initial begin
    int exp_tr[20] = '{0,1,6,8, 0,1,7,8, 0,1,2,3,4, 0,1,2,5, 0,1,9};
    rst_a = 1; rst_b = 1; rdy_a = 0; rdy_b = 0; zero_a = 0; zero_b = 0; opc_a = 0; opc_b = 0;
    m_cnt = 0; m_ill = 0; m_merr = 0;
    @(posedge clk); #1;

    // Basic sequencing on A, mem_ready tied high
    set_cfg(1'b0); tie1 = 1'b1;
    push_reset(ST_FETCH, 1'b0); push_reset(ST_FETCH, 1'b0);
    do_instr(OP_R, 0, 0, 0, -1); do_instr(OP_I, 0, 0, 0, -1);
    do_instr(OP_LD, 0, 0, 0, -1); do_instr(OP_SD, 0, 0, 0, -1);
    do_instr(OP_BEQ, 1, 0, 0, -1);
    chk("model_trace_len", q.size(), 22);
    for (int i = 0; i < 20 && i + 2 < q.size(); i++) chk("model_trace", q[i + 2].st, exp_tr[i]);
    done_cnt_a = 0;
    run_queue();
    chk("basic_instret", cnt_a, 5);
    chk("basic_done_pulses", done_cnt_a, 5);

    // Directed corners on A
    tie1 = 1'b0;
    do_instr(OP_BEQ, 0, 0, 0, -1);
    do_instr(OP_LD, 0, 0, 3, -1);
    chk("model_ld_wait3_len", pos, 8);
    do_instr(OP_JAL, 0, 1, 0, -1);
    do_instr(OP_LD, 1, 0, 15, -1);
    do_instr(OP_SD, 0, 2, 2, -1);
    do_instr(OP_R, 0, 16, 0, -1);
    chk("model_fetch_timeout_cycles", last_mem_n, 16);
    do_instr(OP_BEQ, 0, 15, 0, -1);
    do_instr(7'b1111111, 0, 0, 0, -1);
    do_instr(OP_LD, 0, 0, 5, 3);
    do_instr(OP_I, 0, 0, 0, -1);
    run_queue();

    for (int i = 0; i < 150; i++) rand_instr();
    run_queue();

    // DUT B: jal illegal, then counter wrap with a 4-bit counter
    set_cfg(1'b1); tie1 = 1'b1;
    push_reset(ST_FETCH, 1'b1);
    do_instr(OP_JAL, 0, 0, 0, -1);
    for (int i = 0; i < 17; i++) begin
      case (i % 5)
        0: do_instr(OP_R, 0, 0, 0, -1);
        1: do_instr(OP_I, 0, 0, 0, -1);
        2: do_instr(OP_LD, 0, 0, 0, -1);
        3: do_instr(OP_SD, 0, 0, 0, -1);
        default: do_instr(OP_BEQ, 1, 0, 0, -1);
      endcase
    end
    run_queue();
    chk("wrap_instret", {28'd0, cnt_b}, 1);

    tie1 = 1'b0;
    for (int i = 0; i < 100; i++) rand_instr();
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
